// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one SRAM-like memory port between the instruction-fetch requester
// (inst_*) and the load/store requester (data_*). One transaction is
// outstanding at a time. Data normally wins arbitration. After STARVE_LIMIT
// consecutive data grants with a fetch waiting, the next grant goes to the
// fetch.
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   inst_req/inst_addr          fetch request (read, word size)
//   inst_addr_ok/inst_data_ok   fetch address accepted / fetch data valid
//   inst_rdata                  fetch read data
//   data_req/wr/size/wstrb/addr/wdata   load/store request fields
//   data_addr_ok/data_data_ok   data address accepted / load data or store ack
//   data_rdata                  load read data
//   mem_req/wr/size/wstrb/addr/wdata    request to external memory
//   mem_addr_ok/mem_data_ok     memory handshake
//   mem_rdata                   memory read data
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;      // 0 = inst, 1 = data
    logic [3:0]  starve_q, starve_d;
    // High for the single IDLE cycle that follows a completed transaction;
    // no grant is made during it, giving the 3-cycle minimum spacing.
    logic        cool_q, cool_d;

    logic        grant_s;
    logic        win_data_s;
    logic        issue_s;
    logic        sel_data_s;
    logic        in_data_s;

    // Arbitration in IDLE; outputs are gated while reset is asserted
    always_comb begin
        grant_s    = 1'b0;
        win_data_s = 1'b0;
        if (resetn && (state_q == ST_IDLE) && !cool_q) begin
            if (data_req && !(inst_req && (starve_q >= LIMIT_C))) begin
                grant_s    = 1'b1;
                win_data_s = 1'b1;
            end else if (inst_req) begin
                grant_s    = 1'b1;
                win_data_s = 1'b0;
            end else begin
                grant_s    = 1'b0;
                win_data_s = 1'b0;
            end
        end else begin
            grant_s    = 1'b0;
            win_data_s = 1'b0;
        end
    end

    assign issue_s    = grant_s | (resetn & (state_q == ST_ADDR));
    // In ADDR the grant is locked to the registered owner
    assign sel_data_s = (state_q == ST_IDLE) ? win_data_s : owner_q;
    assign in_data_s  = resetn & (state_q == ST_DATA);

    // Memory request fields from the selected requester; inst fields are forced
    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_wstrb = 4'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (issue_s) begin
            mem_req = 1'b1;
            if (sel_data_s) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_wstrb = data_wstrb;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_wr    = 1'b0;
                mem_size  = 2'd2;
                mem_wstrb = 4'd0;
                mem_addr  = inst_addr;
                mem_wdata = 32'd0;
            end
        end else begin
            mem_req = 1'b0;
        end
    end

    assign inst_addr_ok = issue_s & ~sel_data_s & mem_addr_ok;
    assign data_addr_ok = issue_s &  sel_data_s & mem_addr_ok;
    assign inst_data_ok = in_data_s & ~owner_q & mem_data_ok;
    assign data_data_ok = in_data_s &  owner_q & mem_data_ok;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    // Next-state, owner, starvation counter and cool-down flag
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        cool_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    owner_d = win_data_s;
                    if (win_data_s) begin
                        if (inst_req && (starve_q != 4'd15)) begin
                            starve_d = starve_q + 4'd1;
                        end else begin
                            starve_d = starve_q;
                        end
                    end else begin
                        starve_d = 4'd0;
                    end
                    state_d = mem_addr_ok ? ST_DATA : ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (mem_addr_ok) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (mem_data_ok) begin
                    state_d = ST_IDLE;
                    cool_d  = 1'b1;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            starve_q <= 4'd0;
            cool_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            cool_q   <= cool_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Self-checking bench: directed scenarios followed by randomized traffic.
// A transaction-level reference model (busy / address-accepted / gap flags,
// integer starvation count, latched request fields) predicts every output.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model state
    bit          busy, addr_done, own_data, gap;
    int          starve;
    logic        t_wr;
    logic [1:0]  t_size;
    logic [3:0]  t_wstrb;
    logic [31:0] t_addr, t_wdata;

    // Per-cycle expectations
    bit          g, gd;
    logic        e_req, e_wr, e_iaok, e_daok, e_idok, e_ddok;
    logic [1:0]  e_size;
    logic [3:0]  e_wstrb;
    logic [31:0] e_addr, e_wdata;

    // Predict and compare outputs for the inputs currently driven
    task automatic eval();
        #1;
        g = 0; gd = 0;
        e_req = 0; e_wr = 0; e_size = 2'd0; e_wstrb = 4'd0; e_addr = 32'd0; e_wdata = 32'd0;
        e_iaok = 0; e_daok = 0; e_idok = 0; e_ddok = 0;
        if (resetn) begin
            if (!busy && !gap) begin
                if (data_req && !(inst_req && starve >= LIMIT)) begin g = 1; gd = 1; end
                else if (inst_req) begin g = 1; gd = 0; end
                if (g) begin
                    e_req = 1;
                    if (gd) begin
                        e_wr = data_wr; e_size = data_size; e_wstrb = data_wstrb;
                        e_addr = data_addr; e_wdata = data_wdata;
                        e_daok = mem_addr_ok;
                    end else begin
                        e_size = 2'd2; e_addr = inst_addr;
                        e_iaok = mem_addr_ok;
                    end
                end
            end else if (busy && !addr_done) begin
                e_req = 1;
                e_wr = t_wr; e_size = t_size; e_wstrb = t_wstrb; e_addr = t_addr; e_wdata = t_wdata;
                if (own_data) e_daok = mem_addr_ok; else e_iaok = mem_addr_ok;
            end else if (busy) begin
                if (own_data) e_ddok = mem_data_ok; else e_idok = mem_data_ok;
            end
        end
        chk("mem_req", mem_req, e_req);
        if (e_req || !busy || !resetn) begin
            chk("mem_wr", mem_wr, e_wr);
            chk("mem_size", mem_size, e_size);
            chk("mem_wstrb", mem_wstrb, e_wstrb);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
        end
        chk("inst_addr_ok", inst_addr_ok, e_iaok);
        chk("data_addr_ok", data_addr_ok, e_daok);
        chk("inst_data_ok", inst_data_ok, e_idok);
        chk("data_data_ok", data_data_ok, e_ddok);
        if (e_idok) chk("inst_rdata", inst_rdata, mem_rdata);
        if (e_ddok) chk("data_rdata", data_rdata, mem_rdata);
    endtask

    // Advance one clock and update the reference model
    task automatic adv();
        @(posedge clk);
        if (!resetn) begin
            busy = 0; gap = 0; starve = 0; addr_done = 0;
        end else if (gap) begin
            gap = 0;
        end else if (!busy) begin
            if (g) begin
                busy = 1; own_data = gd; addr_done = mem_addr_ok;
                t_wr = e_wr; t_size = e_size; t_wstrb = e_wstrb; t_addr = e_addr; t_wdata = e_wdata;
                if (gd) begin
                    if (inst_req && starve < 15) starve++;
                end else begin
                    starve = 0;
                end
            end
        end else if (!addr_done) begin
            addr_done = mem_addr_ok;
        end else if (mem_data_ok) begin
            busy = 0; gap = 1;
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        inst_req = 0; inst_addr = 32'd0;
        data_req = 0; data_wr = 0; data_size = 2'd0; data_wstrb = 4'd0;
        data_addr = 32'd0; data_wdata = 32'd0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'd0;
    endtask

    bit exp_seq [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        int k;
        bit post;
        bit ip, dp;
        busy = 0; gap = 0; starve = 0; addr_done = 0; own_data = 0;
        t_wr = 0; t_size = 2'd0; t_wstrb = 4'd0; t_addr = 32'd0; t_wdata = 32'd0;
        clear_inputs();
        resetn = 0; inst_req = 1; data_req = 1;
        inst_addr = 32'h1000_0000; data_addr = 32'h2000_0000;
        @(negedge clk);

        // Reset values with both requests high
        for (int i = 0; i < 2; i++) begin
            mem_addr_ok = 1;
            eval();
            chk("rst_mem_req", mem_req, 1'b0);
            adv();
        end
        resetn = 1;
        eval();
        chk("rst_first_data", data_addr_ok, 1'b1);
        chk("rst_first_inst", inst_addr_ok, 1'b0);
        adv();
        clear_inputs(); mem_data_ok = 1;
        eval(); adv();
        mem_data_ok = 0;
        eval(); adv();

        // Single fetch
        inst_req = 1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1;
        eval();
        chk("fetch_addr", mem_addr, 32'h1c00_0000);
        chk("fetch_wr", mem_wr, 1'b0);
        chk("fetch_size", mem_size, 2'd2);
        chk("fetch_aok", inst_addr_ok, 1'b1);
        adv();
        clear_inputs(); mem_data_ok = 1; mem_rdata = 32'h0280_0c0c;
        eval();
        chk("fetch_dok", inst_data_ok, 1'b1);
        chk("fetch_rdata", inst_rdata, 32'h0280_0c0c);
        chk("fetch_no_ddok", data_data_ok, 1'b0);
        adv();
        clear_inputs();
        eval(); adv();

        // Store forwarding
        data_req = 1; data_wr = 1; data_size = 2'd0; data_wstrb = 4'h4;
        data_addr = 32'h1c08_00a2; data_wdata = 32'h00ab_0000; mem_addr_ok = 1;
        eval();
        chk("st_wr", mem_wr, 1'b1);
        chk("st_size", mem_size, 2'd0);
        chk("st_wstrb", mem_wstrb, 4'h4);
        chk("st_addr", mem_addr, 32'h1c08_00a2);
        chk("st_wdata", mem_wdata, 32'h00ab_0000);
        adv();
        clear_inputs(); mem_data_ok = 1;
        eval();
        chk("st_dok", data_data_ok, 1'b1);
        adv();
        clear_inputs();
        eval(); adv();

        // Address stall with a fetch arriving mid-stall
        data_req = 1; data_addr = 32'h0000_5554; mem_addr_ok = 0;
        eval(); chk("stall_addr0", mem_addr, 32'h0000_5554); adv();
        inst_req = 1; inst_addr = 32'h0000_8880;
        for (int i = 0; i < 2; i++) begin
            eval();
            chk("stall_addr", mem_addr, 32'h0000_5554);
            chk("stall_req", mem_req, 1'b1);
            adv();
        end
        mem_addr_ok = 1;
        eval();
        chk("stall_daok", data_addr_ok, 1'b1);
        chk("stall_no_iaok", inst_addr_ok, 1'b0);
        adv();
        data_req = 0; mem_addr_ok = 1; mem_data_ok = 1;
        eval(); chk("stall_ddok", data_data_ok, 1'b1); adv();
        mem_data_ok = 0;
        eval();
        chk("gap_no_req", mem_req, 1'b0);
        chk("gap_no_iaok", inst_addr_ok, 1'b0);
        adv();
        eval();
        chk("late_inst_aok", inst_addr_ok, 1'b1);
        chk("late_inst_addr", mem_addr, 32'h0000_8880);
        adv();
        clear_inputs(); mem_data_ok = 1;
        eval(); adv();
        clear_inputs();
        eval(); adv();

        // Starvation: both requesters held high, best-case memory
        resetn = 0; eval(); adv(); resetn = 1;
        inst_req = 1; inst_addr = 32'h0000_0100;
        data_req = 1; data_addr = 32'h0000_0200; data_wr = 0; data_size = 2'd2;
        mem_addr_ok = 1; mem_data_ok = 1;
        k = 0;
        for (int i = 0; i < 40 && k < 10; i++) begin
            eval();
            post = 0;
            if (data_addr_ok || inst_addr_ok) begin
                chk("starve_order", data_addr_ok, exp_seq[k]);
                if (inst_addr_ok) begin
                    chk("starve_pre", dut.starve_q, 4'd4);
                    post = 1;
                end
                k++;
            end
            adv();
            if (post) chk("starve_post", dut.starve_q, 4'd0);
        end
        chk("starve_grants", k, 10);
        clear_inputs();
        eval(); adv(); eval(); adv(); eval(); adv();

        // Reset in the middle of a data transaction
        data_req = 1; data_addr = 32'h0000_0040; mem_addr_ok = 1;
        eval(); adv();
        clear_inputs(); resetn = 0;
        eval(); adv();
        resetn = 1; mem_data_ok = 1;
        eval();
        chk("rstmid_no_ddok", data_data_ok, 1'b0);
        chk("rstmid_no_idok", inst_data_ok, 1'b0);
        adv();
        clear_inputs(); inst_req = 1; inst_addr = 32'h0000_0080; mem_addr_ok = 1;
        eval();
        chk("rstmid_idle_grant", inst_addr_ok, 1'b1);
        adv();
        clear_inputs(); mem_data_ok = 1;
        eval(); adv();
        clear_inputs();
        eval(); adv();

        // Randomized traffic; requesters hold their fields until accepted
        ip = 0; dp = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!ip && ($urandom_range(0, 2) == 0)) begin
                ip = 1; inst_addr = $urandom() & 32'hffff_fffc;
            end
            if (!dp && ($urandom_range(0, 2) == 0)) begin
                dp = 1; data_wr = 1'($urandom_range(0, 1));
                data_size = 2'($urandom_range(0, 2)); data_wstrb = 4'($urandom());
                data_addr = $urandom(); data_wdata = $urandom();
            end
            inst_req = ip; data_req = dp;
            mem_addr_ok = 1'($urandom_range(0, 1));
            mem_data_ok = 1'($urandom_range(0, 1));
            mem_rdata = $urandom();
            resetn = ($urandom_range(0, 149) != 0);
            eval();
            if (!resetn) begin ip = 0; dp = 0; end
            if (e_iaok) ip = 0;
            if (e_daok) dp = 0;
            adv();
        end
        resetn = 1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
